fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode Controller. Owns the PC, issues
//  single-outstanding requests to instruction memory and buffers returned words in a small FIFO.
//  Presents {Instruction, InstrPC} with a valid/ready handshake to decode, and accepts
//  branch/jump redirects from execute.
// PARAMETERS
//  BITS        32      instruction/address width
//  RESET_PC    32'h0   PC loaded on reset
//  FIFO_DEPTH  2       buffered instructions (power of 2, >=2; 2 sustains 1 instr/cycle)
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  ImemReq       out  1     fetch request valid
//  ImemAddr      out  BITS  fetch byte address (word aligned)
//  ImemAck       in   1     memory returns ImemRdata this cycle (may be same cycle as ImemReq)
//  ImemRdata     in   BITS  fetched instruction word
//  Instruction   out  BITS  FIFO head -> Controller.Instruction
//  InstrPC       out  BITS  PC of Instruction
//  InstrValid    out  1     head valid
//  InstrReady    in   1     decode accepts head (pop when InstrValid & InstrReady)
//  Redirect      in   1     taken branch/jump, 1-cycle pulse
//  RedirectPC    in   BITS  new fetch target
//  Misaligned    out  1     sticky misaligned-target flag (MISALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset (async assert, sync-safe release): pc=RESET_PC, FIFO empty, epoch=0, state=FETCH,
//   ImemReq=0, ImemAddr=RESET_PC, InstrValid=0, Instruction=32'h00000013 (NOP), InstrPC=0,
//   Misaligned=0. First ImemReq rises the cycle after rst_n deasserts.
//  FSM: FETCH - ImemReq=1 if (count+inflight)<FIFO_DEPTH, else 0; ImemReq && !ImemAck -> WAIT.
//       WAIT  - ImemReq held 1, ImemAddr held stable until ImemAck; ImemAck -> FETCH.
//  ImemAddr/ImemReq are registered; once raised they do not drop or change until ImemAck.
//  On ImemAck (edge): if req_epoch==epoch push {ImemRdata, ImemAddr}, pc<=pc+4 (mod 2^BITS,
//   wraps silently); else discard word (stale).
//  Throughput: zero-wait memory (ack same cycle) + InstrReady=1 -> one instruction per cycle.
//  Latency: ack at edge N -> InstrValid=1 after edge N (empty FIFO; no bypass).
//  Outputs: InstrValid=(count!=0); Instruction/InstrPC = head entry; Instruction=NOP when empty.
//  Push and pop in same edge: count unchanged. Push never occurs when full (issue-gated).
//  Redirect (edge): FIFO flushed (InstrValid=0 next cycle, pop ignored), epoch toggles,
//   pc<=RedirectPC. Request in WAIT completes at its old address; its word is discarded; next
//   request uses RedirectPC. Redirect same edge as ImemAck: word discarded, pc<=RedirectPC.
//   Redirect in FETCH with no request outstanding: next ImemAddr=RedirectPC.
//   Back-to-back redirects: last one wins.
//  Reset mid-WAIT: state dropped; any later ImemAck ignored until a new ImemReq is issued.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: Redirect with RedirectPC[1:0]!=0 sets Misaligned=1, flushes FIFO,
//   stops issuing new requests (outstanding one completes and is discarded); Misaligned clears
//   and fetch resumes on next Redirect with aligned target. Only rst_n clears it otherwise.
//  Not defined: Misaligned tied 0; RedirectPC[1:0] ignored (forced to 2'b00).
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs at reset values immediately; release -> ImemAddr=0.
//  2 Zero-wait stream, InstrReady=1: ImemAck tied to ImemReq -> InstrPC 0,4,8,12 on
//    consecutive cycles, Instruction matches memory words.
//  3 Backpressure: InstrReady=0 for 5 cycles -> count saturates at 2, ImemReq=0, no lost or
//    duplicated instruction; release -> sequence resumes in order.
//  4 Redirect in WAIT (3-cycle memory): Redirect to 0x100 while fetching 0x8 -> 0x8 word
//    never appears; next InstrPC=0x100.
//  5 Redirect same edge as ImemAck and same edge as pop -> FIFO empty next cycle, next
//    InstrPC=RedirectPC, nothing else emitted.
//  6 MISALIGN_CHECK_EN: Redirect to 0x102 -> Misaligned=1, ImemReq stays 0; Redirect to
//    0x200 -> Misaligned=0, fetch from 0x200. Without macro: fetch from 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, keeps at most one instruction-memory request in
// flight and buffers returned words in a small FIFO feeding decode.
// Optional feature: define MISALIGN_CHECK_EN to trap misaligned redirect
// targets (sticky Misaligned flag, fetch stalls until an aligned redirect).
module fetch_unit #(
  parameter int              BITS       = 32,
  parameter logic [BITS-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ImemReq,
  output logic [BITS-1:0] ImemAddr,
  input  logic            ImemAck,
  input  logic [BITS-1:0] ImemRdata,
  output logic [BITS-1:0] Instruction,
  output logic [BITS-1:0] InstrPC,
  output logic            InstrValid,
  input  logic            InstrReady,
  input  logic            Redirect,
  input  logic [BITS-1:0] RedirectPC,
  output logic            Misaligned
);
  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [BITS-1:0]  NOP     = BITS'(32'h0000_0013);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  typedef struct packed {
    logic [BITS-1:0] instr;
    logic [BITS-1:0] pc;
  } entry_t;

  state_t                     state_q, state_d;
  logic   [BITS-1:0]          pc_q, pc_d;
  logic   [BITS-1:0]          addr_q, addr_d;
  logic                       req_q, req_d;
  logic                       req_epoch_q, req_epoch_d;
  logic                       epoch_q, epoch_d;
  entry_t [FIFO_DEPTH-1:0]    fifo_q, fifo_d;
  logic   [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic   [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic   [CNT_W-1:0]         cnt_q, cnt_d;

  logic            mis_d;
  logic [BITS-1:0] redir_tgt;
  logic            push, pop;

`ifdef MISALIGN_CHECK_EN
  logic mis_q;

  // Sticky misaligned flag: any redirect re-evaluates it, nothing else does.
  always_comb begin
    mis_d = mis_q;
    if (Redirect) mis_d = |RedirectPC[1:0];
  end

  // Misaligned flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign redir_tgt  = RedirectPC;
  assign Misaligned = mis_q;
`else
  logic [1:0] unused_redir_lo;
  assign unused_redir_lo = RedirectPC[1:0];
  assign mis_d           = 1'b0;
  assign redir_tgt       = {RedirectPC[BITS-1:2], 2'b00};
  assign Misaligned      = 1'b0;
`endif

  // A returned word is kept only if no redirect happened since it was issued
  // (epoch match) and no redirect lands on the same edge.
  assign push = req_q && ImemAck && (req_epoch_q == epoch_q) && !Redirect;
  assign pop  = InstrValid && InstrReady && !Redirect;

  // Request FSM: WAIT while a raised request has not yet been acknowledged.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (req_q && !ImemAck) state_d = S_WAIT;
      S_WAIT:  if (ImemAck)           state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // FIFO, PC and epoch update; a redirect flushes and overrides everything.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{instr: ImemRdata, pc: addr_q};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      pc_d             = pc_q + BITS'(4);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (Redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      epoch_d  = ~epoch_q;
      pc_d     = redir_tgt;
    end
  end

  // Issue: hold an unacked request stable; otherwise issue at the next PC
  // only if the word is guaranteed a FIFO slot (count + inflight < depth).
  always_comb begin
    req_d       = 1'b0;
    addr_d      = pc_d;
    req_epoch_d = req_epoch_q;
    if (state_d == S_WAIT) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else if ((cnt_d < DEPTH_C) && !mis_d) begin
      req_d       = 1'b1;
      req_epoch_d = epoch_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ImemReq     = req_q;
  assign ImemAddr    = addr_q;
  assign InstrValid  = (cnt_q != '0);
  assign Instruction = InstrValid ? fifo_q[rd_ptr_q].instr : NOP;
  assign InstrPC     = InstrValid ? fifo_q[rd_ptr_q].pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized stimulus against a sequence-level
// reference model (expected PC stream and memory contents function).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        Misaligned;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int mark;
  logic [31:0] exp_pc = '0;

  // memory model controls
  int   lat_mode = 0;   // 0: fixed latency, 1: random 0..3 per request
  int   fixed_lat = 0;
  int   rnd_lat, wcnt, eff_lat;
  logic stray_ack = 1'b0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // instruction memory: acks after wcnt >= latency cycles of held request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 0;
      rnd_lat <= 0;
    end else if (ImemReq && ImemAck) begin
      wcnt    <= 0;
      rnd_lat <= int'($urandom_range(0, 3));
    end else if (ImemReq) begin
      wcnt <= wcnt + 1;
    end
  end
  assign eff_lat   = (lat_mode != 0) ? rnd_lat : fixed_lat;
  assign ImemAck   = (ImemReq && (wcnt >= eff_lat)) || stray_ack;
  assign ImemRdata = stray_ack ? 32'hBAD0_BAD0 : memw(ImemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: called just after a negedge with inputs set. Scores a pop on
  // the coming edge against the expected stream, then applies the redirect.
  task automatic tick();
    #1;
    if (!Redirect && InstrValid && InstrReady) begin
      chk("pop_pc", InstrPC, exp_pc);
      chk("pop_instr", Instruction, memw(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (Redirect) begin
`ifdef MISALIGN_CHECK_EN
      exp_pc = RedirectPC;
`else
      exp_pc = RedirectPC & ~32'h3;
`endif
    end
    @(negedge clk);
    Redirect = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   32'(ImemReq), 32'h0);
    chk({tag, "_addr"},  ImemAddr, 32'h0);
    chk({tag, "_valid"}, 32'(InstrValid), 32'h0);
    chk({tag, "_instr"}, Instruction, 32'h0000_0013);
    chk({tag, "_pc"},    InstrPC, 32'h0);
    chk({tag, "_mis"},   32'(Misaligned), 32'h0);
  endtask

  initial begin
    // ---- reset state and first request timing
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    #1 chk("req_before_first_edge", 32'(ImemReq), 32'h0);
    exp_pc = 32'h0;
    pops = 0;
    tick();
    chk("first_req", 32'(ImemReq), 32'h1);
    chk("first_addr", ImemAddr, 32'h0);

    // ---- zero-wait stream: one instruction per cycle after 2-cycle latency
    repeat (19) tick();
    chk("stream_pops", 32'(pops), 32'd18);

    // ---- backpressure: FIFO fills, request stops, head holds in order
    mark = pops;
    InstrReady = 1'b0;
    repeat (5) tick();
    chk("bp_req_low", 32'(ImemReq), 32'h0);
    chk("bp_valid", 32'(InstrValid), 32'h1);
    chk("bp_head_pc", InstrPC, exp_pc);
    chk("bp_no_pops", 32'(pops - mark), 32'd0);
    InstrReady = 1'b1;
    repeat (10) tick();

    // ---- random latency, ready and redirects
    mark = pops;
    lat_mode = 1;
    for (int i = 0; i < 300; i++) begin
      InstrReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        Redirect   = 1'b1;
        RedirectPC = 32'($urandom_range(0, 1023)) << 2;
      end
      tick();
    end
    chk("rand_progress", 32'(pops - mark >= 30), 32'h1);
    lat_mode   = 0;
    InstrReady = 1'b1;

    // ---- reset mid-WAIT, stray ack around release must be ignored
    fixed_lat = 5;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    stray_ack = 1'b1;
    #1 chk_reset_outs("midreset");
    @(negedge clk);
    fixed_lat = 3;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    tick();
    stray_ack = 1'b0;
    chk("stray_ignored", 32'(InstrValid), 32'h0);
    chk("rel_addr", ImemAddr, 32'h0);

    // ---- redirect while waiting on 0x8 (3-cycle memory)
    for (int i = 0; i < 50 && !(ImemReq && ImemAddr == 32'h8); i++) tick();
    chk("wait_addr8", ImemAddr, 32'h8);
    tick();
    Redirect   = 1'b1;
    RedirectPC = 32'h100;
    tick();
    chk("wait_hold_req", 32'(ImemReq), 32'h1);
    chk("wait_hold_addr", ImemAddr, 32'h8);
    mark = pops;
    repeat (20) tick();
    chk("after_wait_redirect_pops", 32'(pops - mark > 0), 32'h1);

    // ---- redirect on same edge as ack and pop
    fixed_lat = 0;
    repeat (6) tick();
    chk("e_steady", 32'({InstrValid, ImemReq, ImemAck}), 32'h7);
    Redirect   = 1'b1;
    RedirectPC = 32'h300;
    tick();
    chk("e_flushed", 32'(InstrValid), 32'h0);
    chk("e_addr", ImemAddr, 32'h300);
    tick();
    chk("e_first_valid", 32'(InstrValid), 32'h1);
    chk("e_first_pc", InstrPC, 32'h300);
    repeat (5) tick();

    // ---- misaligned redirect target
    Redirect   = 1'b1;
    RedirectPC = 32'h102;
    tick();
`ifdef MISALIGN_CHECK_EN
    chk("mis_set", 32'(Misaligned), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mis_req_low", 32'(ImemReq), 32'h0);
      chk("mis_empty", 32'(InstrValid), 32'h0);
    end
    Redirect   = 1'b1;
    RedirectPC = 32'h200;
    tick();
    chk("mis_clear", 32'(Misaligned), 32'h0);
    chk("mis_resume_addr", ImemAddr, 32'h200);
    tick();
    chk("mis_resume_pc", InstrPC, 32'h200);
`else
    chk("mis_tied0", 32'(Misaligned), 32'h0);
    chk("mis_aligned_addr", ImemAddr, 32'h100);
    tick();
    chk("mis_aligned_pc", InstrPC, 32'h100);
`endif
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound so the run always terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
